// File: rtl/prog_loader_pkg.sv
// Shared definitions for the boot-time program loader: FSM state encodings and word geometry.
// Contents: state_t (CNT_HI, CNT_LO, DATA, WR, RUN, ERR), WORD_BYTES, BYTE_IDX_LAST.
// Imported by prog_loader and prog_loader_byte_packer.
package prog_loader_pkg;

   // Bytes per instruction word on the serial stream.
   localparam int WORD_BYTES = 4;

   // Byte-counter value at which the incoming byte completes a word.
   localparam logic [1:0] BYTE_IDX_LAST = 2'(WORD_BYTES - 1);

   typedef enum logic [2:0] {
      ST_CNT_HI = 3'd0,
      ST_CNT_LO = 3'd1,
      ST_DATA   = 3'd2,
      ST_WR     = 3'd3,
      ST_RUN    = 3'd4,
      ST_ERR    = 3'd5
   } state_t;

endpackage

// File: rtl/prog_loader_byte_packer.sv
// 8->32 MSB-first byte packer with a 2-bit byte counter; the first byte of a word lands in bits[31:24].
// Ports: i_clk, i_rst (sync, active-high), i_clr (loader clear), i_byte_vld/i_byte_dat (accepted byte),
//        o_word (word as it would be after this byte), o_word_full (this byte completes the word).
module prog_loader_byte_packer
   import prog_loader_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_clr,
   input  logic        i_byte_vld,
   input  logic [7:0]  i_byte_dat,
   output logic [31:0] o_word,
   output logic        o_word_full
);

   // Only the three most recent bytes need storing; the fourth arrives on the completing cycle.
   logic [23:0] r_word;
   logic [1:0]  r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_word <= '0;
         r_cnt  <= '0;
      end else if (i_byte_vld) begin
         r_word <= {r_word[15:0], i_byte_dat};
         // Wraps to 0 after the last byte, so the next word starts clean without an explicit clear.
         r_cnt  <= r_cnt + 2'd1;
      end
   end

   // Combinational look-ahead so the loader can register the full word on the completing accept edge.
   assign o_word      = {r_word, i_byte_dat};
   assign o_word_full = i_byte_vld && (r_cnt == BYTE_IDX_LAST);

endmodule

// File: rtl/prog_loader.sv
// Boot loader: receives a 16-bit word count then MSB-first program words, writes them to imem from addr 0,
// then releases the core (pcclr=1) until it reports fin, after which it re-clears and awaits a new program.
// Ports: i_clk, i_rst, i_rx_data/i_rx_valid/o_rx_ready (byte stream), o_im_we/o_im_addr/o_im_wdata (imem),
//        o_pcclr (active-low core clear), i_fin, o_done (== o_pcclr), o_err (count too large, sticky).
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [7:0]        i_rx_data,
   input  logic              i_rx_valid,
   output logic              o_rx_ready,
   output logic              o_im_we,
   output logic [ADDR_W-1:0] o_im_addr,
   output logic [31:0]       o_im_wdata,
   output logic              o_pcclr,
   input  logic              i_fin,
   output logic              o_done,
   output logic              o_err
);

   // Capacity in words, widened so 2**16 is representable.
   localparam logic [16:0] CAP = 17'd1 << ADDR_W;

   state_t            r_state;
   logic [15:0]       r_count;
   logic [ADDR_W:0]   r_idx;
   logic              r_im_we;
   logic [ADDR_W-1:0] r_im_addr;
   logic [31:0]       r_im_wdata;
   logic              r_pcclr;
   logic              r_done;
   logic              r_err;

   logic              w_rx_ready;
   logic              w_accept;
   logic [15:0]       w_n;
   logic [ADDR_W:0]   w_idx_nxt;
   logic [31:0]       w_word;
   logic              w_word_full;
   logic              w_pk_clr;

   always_comb begin
      w_rx_ready = 1'b0;
      if (!i_rst) begin
         case (r_state)
            ST_CNT_HI, ST_CNT_LO, ST_DATA: w_rx_ready = 1'b1;
            default:                       w_rx_ready = 1'b0;
         endcase
      end
   end

   assign w_accept  = i_rx_valid && w_rx_ready;
   assign w_n       = {r_count[15:8], i_rx_data};
   assign w_idx_nxt = r_idx + 1'b1;
   // The packer only holds partial words while in DATA; anywhere else a leftover byte is stale.
   assign w_pk_clr  = (r_state != ST_DATA);

   prog_loader_byte_packer u_packer (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_clr       (w_pk_clr),
      .i_byte_vld  (w_accept && (r_state == ST_DATA)),
      .i_byte_dat  (i_rx_data),
      .o_word      (w_word),
      .o_word_full (w_word_full)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= ST_CNT_HI;
         r_count    <= '0;
         r_idx      <= '0;
         r_im_we    <= 1'b0;
         r_im_addr  <= '0;
         r_im_wdata <= '0;
         r_pcclr    <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         case (r_state)
            ST_CNT_HI: begin
               if (w_accept) begin
                  r_count[15:8] <= i_rx_data;
                  r_state       <= ST_CNT_LO;
               end
            end
            ST_CNT_LO: begin
               if (w_accept) begin
                  r_count <= w_n;
                  if (w_n == 16'd0) begin
                     r_pcclr <= 1'b1;
                     r_done  <= 1'b1;
                     r_state <= ST_RUN;
                  end else if ({1'b0, w_n} > CAP) begin
                     r_err   <= 1'b1;
                     r_state <= ST_ERR;
                  end else begin
                     r_state <= ST_DATA;
                  end
               end
            end
            ST_DATA: begin
               // Register the write on the completing accept so it is presented during WR.
               if (w_word_full) begin
                  r_im_we    <= 1'b1;
                  r_im_addr  <= r_idx[ADDR_W-1:0];
                  r_im_wdata <= w_word;
                  r_state    <= ST_WR;
               end
            end
            ST_WR: begin
               r_im_we <= 1'b0;
               r_idx   <= w_idx_nxt;
               // N is at most 2**ADDR_W here, so a 16-bit compare of index+1 against N is exact.
               if (16'(w_idx_nxt) == r_count) begin
                  r_pcclr <= 1'b1;
                  r_done  <= 1'b1;
                  r_state <= ST_RUN;
               end else begin
                  r_state <= ST_DATA;
               end
            end
            ST_RUN: begin
               if (i_fin) begin
                  r_pcclr <= 1'b0;
                  r_done  <= 1'b0;
                  r_idx   <= '0;
                  r_state <= ST_CNT_HI;
               end
            end
            ST_ERR: begin
               r_err   <= 1'b1;
               r_pcclr <= 1'b0;
               r_done  <= 1'b0;
            end
            default: r_state <= ST_ERR;
         endcase
      end
   end

   assign o_rx_ready = w_rx_ready;
   assign o_im_we    = r_im_we;
   assign o_im_addr  = r_im_addr;
   assign o_im_wdata = r_im_wdata;
   assign o_pcclr    = r_pcclr;
   assign o_done     = r_done;
   assign o_err      = r_err;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: a default-size instance (ADDR_W=8) and a small one (ADDR_W=2).
// Inputs driven 1 time unit after posedge; outputs sampled then or at negedge (write monitor).
// Each scenario task performs its own inline comparisons against hand-computed values.
module tb_prog_loader;

   logic        clk;
   logic        rst;
   logic [7:0]  rx_data;
   logic        rx_valid, rx_valid2;
   logic        fin, fin2;

   logic        rx_ready, im_we, pcclr, done, err;
   logic [7:0]  im_addr;
   logic [31:0] im_wdata;

   logic        rx_ready2, im_we2, pcclr2, done2, err2;
   logic [1:0]  im_addr2;
   logic [31:0] im_wdata2;

   int n_chk  = 0;
   int n_fail = 0;

   logic [7:0]  q_addr[$];
   logic [31:0] q_data[$];
   logic [1:0]  q2_addr[$];
   logic [31:0] q2_data[$];

   prog_loader #(.ADDR_W(8)) dut (
      .i_clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid), .o_rx_ready(rx_ready),
      .o_im_we(im_we), .o_im_addr(im_addr), .o_im_wdata(im_wdata), .o_pcclr(pcclr),
      .i_fin(fin), .o_done(done), .o_err(err)
   );

   prog_loader #(.ADDR_W(2)) dut2 (
      .i_clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid2), .o_rx_ready(rx_ready2),
      .o_im_we(im_we2), .o_im_addr(im_addr2), .o_im_wdata(im_wdata2), .o_pcclr(pcclr2),
      .i_fin(fin2), .o_done(done2), .o_err(err2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(negedge clk) begin
      if (im_we) begin
         q_addr.push_back(im_addr);
         q_data.push_back(im_wdata);
      end
      if (im_we2) begin
         q2_addr.push_back(im_addr2);
         q2_data.push_back(im_wdata2);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one byte and hold it until accepted (bounded wait).
   task automatic send_byte(input bit sel, input logic [7:0] b);
      int waited = 0;
      rx_data = b;
      if (sel) rx_valid2 = 1'b1; else rx_valid = 1'b1;
      while (!(sel ? rx_ready2 : rx_ready) && waited < 50) begin
         tick();
         waited++;
      end
      if (waited >= 50) begin
         n_chk++;
         n_fail++;
         $display("FAIL send_timeout: byte %h not accepted after %0d cycles, required acceptance", b, waited);
      end else begin
         tick();
      end
      rx_valid  = 1'b0;
      rx_valid2 = 1'b0;
   endtask

   task automatic send_count(input bit sel, input logic [15:0] n);
      send_byte(sel, n[15:8]);
      send_byte(sel, n[7:0]);
   endtask

   task automatic send_word(input bit sel, input logic [31:0] w);
      send_byte(sel, w[31:24]);
      send_byte(sel, w[23:16]);
      send_byte(sel, w[15:8]);
      send_byte(sel, w[7:0]);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
   endtask

   task automatic pulse_fin();
      fin = 1'b1;
      tick();
      fin = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      n_chk++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL reset_rx_ready: got %b need 0", rx_ready); end
      n_chk++; if ({im_we, im_addr, im_wdata, pcclr, done, err} !== 44'd0) begin
         n_fail++; $display("FAIL reset_outputs: we=%b addr=%h wdata=%h pcclr=%b done=%b err=%b need all 0",
                            im_we, im_addr, im_wdata, pcclr, done, err);
      end
      rst = 1'b0;
      #1;
      n_chk++; if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_rdy: got %b need 1", rx_ready); end
   endtask

   task automatic test_two_words();
      q_addr.delete(); q_data.delete();
      send_count(0, 16'h0002);
      send_word(0, 32'h20080005);
      n_chk++; if (pcclr !== 1'b0) begin n_fail++; $display("FAIL tw_hold_mid: pcclr got %b need 0", pcclr); end
      send_word(0, 32'hAC080004);
      // Now in WR of the second word.
      n_chk++; if (im_we !== 1'b1 || pcclr !== 1'b0 || rx_ready !== 1'b0) begin
         n_fail++; $display("FAIL tw_wr_cycle: we=%b pcclr=%b rdy=%b need 1 0 0", im_we, pcclr, rx_ready);
      end
      tick();
      n_chk++; if (pcclr !== 1'b1 || done !== 1'b1 || im_we !== 1'b0) begin
         n_fail++; $display("FAIL tw_release: pcclr=%b done=%b we=%b need 1 1 0", pcclr, done, im_we);
      end
      n_chk++; if (q_addr.size() !== 2) begin n_fail++; $display("FAIL tw_nwrites: got %0d need 2", q_addr.size()); end
      else begin
         n_chk++; if (q_addr[0] !== 8'd0 || q_data[0] !== 32'h20080005) begin
            n_fail++; $display("FAIL tw_w0: got %h/%h need 00/20080005", q_addr[0], q_data[0]);
         end
         n_chk++; if (q_addr[1] !== 8'd1 || q_data[1] !== 32'hAC080004) begin
            n_fail++; $display("FAIL tw_w1: got %h/%h need 01/ac080004", q_addr[1], q_data[1]);
         end
      end
      n_chk++; if (im_addr !== 8'd1 || im_wdata !== 32'hAC080004) begin
         n_fail++; $display("FAIL tw_hold_vals: got %h/%h need 01/ac080004", im_addr, im_wdata);
      end
   endtask

   task automatic test_fin_reload();
      pulse_fin();
      n_chk++; if (pcclr !== 1'b0 || done !== 1'b0 || rx_ready !== 1'b1) begin
         n_fail++; $display("FAIL fin_clear: pcclr=%b done=%b rdy=%b need 0 0 1", pcclr, done, rx_ready);
      end
      q_addr.delete(); q_data.delete();
      fin = 1'b1;  // must be ignored outside RUN
      send_count(0, 16'h0001);
      send_byte(0, 8'h12);
      send_byte(0, 8'h34);
      send_byte(0, 8'h56);
      fin = 1'b0;
      send_byte(0, 8'h78);
      tick();
      n_chk++; if (pcclr !== 1'b1) begin n_fail++; $display("FAIL fin_reload_run: pcclr got %b need 1", pcclr); end
      n_chk++; if (q_addr.size() !== 1 || q_addr[0] !== 8'd0 || q_data[0] !== 32'h12345678) begin
         n_fail++; $display("FAIL fin_reload_wr: n=%0d addr=%h data=%h need 1/00/12345678",
                            q_addr.size(), q_addr[0], q_data[0]);
      end
   endtask

   task automatic test_zero_count();
      pulse_fin();
      q_addr.delete(); q_data.delete();
      send_count(0, 16'h0000);
      n_chk++; if (pcclr !== 1'b1 || done !== 1'b1 || rx_ready !== 1'b0) begin
         n_fail++; $display("FAIL zero_release: pcclr=%b done=%b rdy=%b need 1 1 0", pcclr, done, rx_ready);
      end
      tick();
      n_chk++; if (q_addr.size() !== 0) begin n_fail++; $display("FAIL zero_nowrite: got %0d writes need 0", q_addr.size()); end
   endtask

   task automatic test_gappy();
      logic [31:0] words[3];
      logic [31:0] w;
      words[0] = 32'h11223344; words[1] = 32'h55667788; words[2] = 32'h99AABBCC;
      pulse_fin();
      q_addr.delete(); q_data.delete();
      send_count(0, 16'h0003);
      for (int i = 0; i < 3; i++) begin
         w = words[i];
         for (int j = 3; j >= 0; j--) begin
            rx_data = 8'($urandom);  // garbage while idle
            repeat ($urandom_range(0, 3)) tick();
            send_byte(0, w[j*8 +: 8]);
         end
      end
      tick();
      n_chk++; if (q_addr.size() !== 3) begin n_fail++; $display("FAIL gap_nwrites: got %0d need 3", q_addr.size()); end
      else begin
         for (int i = 0; i < 3; i++) begin
            n_chk++; if (q_addr[i] !== 8'(i) || q_data[i] !== words[i]) begin
               n_fail++; $display("FAIL gap_w%0d: got %h/%h need %h/%h", i, q_addr[i], q_data[i], 8'(i), words[i]);
            end
         end
      end
      n_chk++; if (pcclr !== 1'b1) begin n_fail++; $display("FAIL gap_release: pcclr got %b need 1", pcclr); end
   endtask

   task automatic test_rst_mid_load();
      pulse_fin();
      send_count(0, 16'h0003);
      send_word(0, 32'hCAFEF00D);
      send_byte(0, 8'hA1);
      send_byte(0, 8'hA2);
      rst = 1'b1;
      tick();
      n_chk++; if ({im_we, im_addr, im_wdata, pcclr, done, err, rx_ready} !== 45'd0) begin
         n_fail++; $display("FAIL rst_mid_outputs: we=%b addr=%h wdata=%h pcclr=%b done=%b err=%b rdy=%b need all 0",
                            im_we, im_addr, im_wdata, pcclr, done, err, rx_ready);
      end
      rst = 1'b0;
      #1;
      q_addr.delete(); q_data.delete();
      send_count(0, 16'h0001);
      send_word(0, 32'hDEADBEEF);
      tick();
      n_chk++; if (q_addr.size() !== 1 || q_addr[0] !== 8'd0 || q_data[0] !== 32'hDEADBEEF) begin
         n_fail++; $display("FAIL rst_fresh_wr: n=%0d addr=%h data=%h need 1/00/deadbeef",
                            q_addr.size(), q_addr[0], q_data[0]);
      end
      n_chk++; if (pcclr !== 1'b1 || done !== 1'b1) begin
         n_fail++; $display("FAIL rst_fresh_run: pcclr=%b done=%b need 1 1", pcclr, done);
      end
   endtask

   task automatic test_small_capacity();
      logic [31:0] words[4];
      words[0] = 32'h0A0B0C0D; words[1] = 32'h1A1B1C1D; words[2] = 32'h2A2B2C2D; words[3] = 32'h3A3B3C3D;
      do_reset();
      send_count(1, 16'h0005);
      n_chk++; if (err2 !== 1'b1 || rx_ready2 !== 1'b0 || pcclr2 !== 1'b0) begin
         n_fail++; $display("FAIL cap_over: err=%b rdy=%b pcclr=%b need 1 0 0", err2, rx_ready2, pcclr2);
      end
      fin2 = 1'b1;
      repeat (3) tick();
      fin2 = 1'b0;
      n_chk++; if (err2 !== 1'b1 || rx_ready2 !== 1'b0 || pcclr2 !== 1'b0 || done2 !== 1'b0) begin
         n_fail++; $display("FAIL cap_sticky: err=%b rdy=%b pcclr=%b done=%b need 1 0 0 0", err2, rx_ready2, pcclr2, done2);
      end
      do_reset();
      n_chk++; if (err2 !== 1'b0) begin n_fail++; $display("FAIL cap_err_clr: got %b need 0", err2); end
      q2_addr.delete(); q2_data.delete();
      send_count(1, 16'h0004);
      for (int i = 0; i < 4; i++) send_word(1, words[i]);
      n_chk++; if (pcclr2 !== 1'b0) begin n_fail++; $display("FAIL cap_last_wr_hold: pcclr got %b need 0", pcclr2); end
      tick();
      n_chk++; if (pcclr2 !== 1'b1 || err2 !== 1'b0) begin
         n_fail++; $display("FAIL cap_full_release: pcclr=%b err=%b need 1 0", pcclr2, err2);
      end
      n_chk++; if (q2_addr.size() !== 4) begin n_fail++; $display("FAIL cap_nwrites: got %0d need 4", q2_addr.size()); end
      else begin
         for (int i = 0; i < 4; i++) begin
            n_chk++; if (q2_addr[i] !== 2'(i) || q2_data[i] !== words[i]) begin
               n_fail++; $display("FAIL cap_w%0d: got %h/%h need %h/%h", i, q2_addr[i], q2_data[i], 2'(i), words[i]);
            end
         end
      end
   endtask

   initial begin
      rst       = 1'b1;
      rx_data   = 8'h00;
      rx_valid  = 1'b0;
      rx_valid2 = 1'b0;
      fin       = 1'b0;
      fin2      = 1'b0;
      test_reset();
      test_two_words();
      test_fin_reload();
      test_zero_count();
      test_gappy();
      test_rst_mid_load();
      test_small_capacity();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
